nios2_oci_trace_capture: RTL and testbench

//  Parametrised capture buffer for Nios II OCI data-compression trace (dct) words.

---
 rtl/nios2_oci_trace_capture_pkg.sv | 28 ++
 rtl/nios2_oci_trace_capture_if.sv | 34 +++
 rtl/nios2_oci_trace_capture_fifo.sv | 68 ++++++
 rtl/nios2_oci_trace_capture.sv | 86 ++++++++
 tb/tb_nios2_oci_trace_capture.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/nios2_oci_trace_capture_pkg.sv
// Shared types and helpers for the Nios II OCI dct trace capture block:
// FSM encoding, pointer/fill width helpers and a saturating increment.
package nios2_oci_trace_pkg;

  typedef enum logic [1:0] {
    CAPTURE = 2'd0,
    DRAIN   = 2'd1,
    DONE    = 2'd2
  } trace_state_e;

  localparam int DEFAULT_DEPTH = 16;

  // Widths are derived from DEPTH, which is assumed to be a power of two.
  function automatic int ptrWidth(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int fillWidth(input int depth);
    return ptrWidth(depth) + 1;
  endfunction

  function automatic logic [63:0] satInc(input logic [63:0] value, input int unsigned width);
    logic [63:0] maxVal;
    maxVal = (width >= 64) ? {64{1'b1}} : ((64'd1 << width) - 64'd1);
    return (value == maxVal) ? value : value + 64'd1;
  endfunction

endpackage

// File: rtl/nios2_oci_trace_capture_if.sv
// Capture-side and read-side signals of the trace capture buffer.
// The master modport belongs to the trace packer/consumer, slave to the buffer.
interface nios2_oci_trace_capture_if #(
  parameter int DATA_W = 30,
  parameter int CNT_W  = 4,
  parameter int DEPTH  = nios2_oci_trace_pkg::DEFAULT_DEPTH,
  parameter int DROP_W = 16
);
  localparam int FILL_W = nios2_oci_trace_pkg::fillWidth(DEPTH);

  logic              dct_valid;
  logic [DATA_W-1:0] dct_buffer;
  logic [CNT_W-1:0]  dct_count;
  logic              test_ending;
  logic              rd_valid;
  logic              rd_ready;
  logic [DATA_W-1:0] rd_data;
  logic [CNT_W-1:0]  rd_count;
  logic [FILL_W-1:0] fill_level;
  logic              overflow;
  logic [DROP_W-1:0] drop_count;
  logic              test_has_ended;

  modport master (
    output dct_valid, dct_buffer, dct_count, test_ending, rd_ready,
    input  rd_valid, rd_data, rd_count, fill_level, overflow, drop_count, test_has_ended
  );

  modport slave (
    input  dct_valid, dct_buffer, dct_count, test_ending, rd_ready,
    output rd_valid, rd_data, rd_count, fill_level, overflow, drop_count, test_has_ended
  );

endinterface

// File: rtl/nios2_oci_trace_capture_fifo.sv
// Circular buffer with show-ahead read; when OVERWRITE is set a write into a
// full buffer replaces the oldest entry instead of being discarded.
module nios2_oci_trace_fifo
  import nios2_oci_trace_pkg::*;
#(
  parameter int WIDTH     = 34,
  parameter int DEPTH     = DEFAULT_DEPTH,
  parameter int OVERWRITE = 0
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          i_wr,
  input  logic                          i_pop,
  input  logic [WIDTH-1:0]              i_wrData,
  output logic [WIDTH-1:0]              o_rdData,
  output logic [fillWidth(DEPTH)-1:0]   o_fill,
  output logic                          o_full,
  output logic                          o_empty
);

  localparam int PTR_W  = ptrWidth(DEPTH);
  localparam int FILL_W = fillWidth(DEPTH);

  logic [WIDTH-1:0]  r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wrPtr;
  logic [PTR_W-1:0]  r_rdPtr;
  logic [FILL_W-1:0] r_fill;
  logic              w_store;
  logic              w_advRd;

  assign o_full  = (r_fill == FILL_W'(DEPTH));
  assign o_empty = (r_fill == '0);
  assign o_fill  = r_fill;

  // A full buffer accepts a write only alongside a pop or in overwrite mode;
  // overwriting pushes the read pointer past the lost oldest entry.
  assign w_store = i_wr & (~o_full | i_pop | (OVERWRITE != 0));
  assign w_advRd = i_pop | (i_wr & o_full & (OVERWRITE != 0));

  assign o_rdData = o_empty ? '0 : r_mem[r_rdPtr];

  always_ff @(posedge clk) begin
    if (w_store) begin
      r_mem[r_wrPtr] <= i_wrData;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_fill  <= '0;
    end else begin
      if (w_store) begin
        r_wrPtr <= r_wrPtr + 1'b1;
      end
      if (w_advRd) begin
        r_rdPtr <= r_rdPtr + 1'b1;
      end
      if (w_store && !w_advRd) begin
        r_fill <= r_fill + 1'b1;
      end else if (w_advRd && !w_store) begin
        r_fill <= r_fill - 1'b1;
      end
    end
  end

endmodule

// File: rtl/nios2_oci_trace_capture.sv
// Top of the dct trace capture buffer: qualifies capture writes, tracks drops,
// and sequences CAPTURE -> DRAIN -> DONE once the test signals its end.
module nios2_oci_trace_capture
  import nios2_oci_trace_pkg::*;
#(
  parameter int DATA_W       = 30,
  parameter int CNT_W        = 4,
  parameter int DEPTH        = DEFAULT_DEPTH,
  parameter int STOP_ON_FULL = 1,
  parameter int DROP_W       = 16
) (
  input logic                      clk,
  input logic                      reset_n,
  nios2_oci_trace_capture_if.slave bus
);

  localparam int FILL_W = fillWidth(DEPTH);
  localparam int WORD_W = CNT_W + DATA_W;

  trace_state_e      r_state;
  logic              r_overflow;
  logic [DROP_W-1:0] r_dropCount;
  logic              r_testHasEnded;

  logic              w_wr;
  logic              w_pop;
  logic              w_full;
  logic              w_empty;
  logic [FILL_W-1:0] w_fill;
  logic [WORD_W-1:0] w_rdWord;

  assign w_wr  = bus.dct_valid & (bus.dct_count != '0) & (r_state == CAPTURE);
  assign w_pop = ~w_empty & bus.rd_ready & (r_state != DONE);

  nios2_oci_trace_fifo #(
    .WIDTH    (WORD_W),
    .DEPTH    (DEPTH),
    .OVERWRITE((STOP_ON_FULL == 0) ? 1 : 0)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .i_wr    (w_wr),
    .i_pop   (w_pop),
    .i_wrData({bus.dct_count, bus.dct_buffer}),
    .o_rdData(w_rdWord),
    .o_fill  (w_fill),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Capture stays open through the cycle that samples test_ending; a drop is
  // any write that meets a full buffer without a simultaneous pop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= CAPTURE;
      r_overflow     <= 1'b0;
      r_dropCount    <= '0;
      r_testHasEnded <= 1'b0;
    end else begin
      case (r_state)
        CAPTURE: if (bus.test_ending) r_state <= DRAIN;
        DRAIN: begin
          if (w_empty && !w_wr) begin
            r_state        <= DONE;
            r_testHasEnded <= 1'b1;
          end
        end
        DONE:    r_testHasEnded <= 1'b1;
        default: r_state <= CAPTURE;
      endcase
      if (w_wr && w_full && !w_pop) begin
        r_overflow  <= 1'b1;
        r_dropCount <= DROP_W'(satInc(64'(r_dropCount), DROP_W));
      end
    end
  end

  assign bus.rd_valid       = ~w_empty;
  assign bus.rd_data        = w_rdWord[DATA_W-1:0];
  assign bus.rd_count       = w_rdWord[DATA_W +: CNT_W];
  assign bus.fill_level     = w_fill;
  assign bus.overflow       = r_overflow;
  assign bus.drop_count     = r_dropCount;
  assign bus.test_has_ended = r_testHasEnded;

endmodule

// File: tb/tb_nios2_oci_trace_capture.sv
// Scoreboard bench for the trace capture buffer: lane 0 runs STOP_ON_FULL=1,
// lane 1 STOP_ON_FULL=0, both fed the same stimulus and checked against a queue model.
module tb_nios2_oci_trace_capture;

  localparam int DATA_W   = 30;
  localparam int CNT_W    = 4;
  localparam int DEPTH    = 16;
  localparam int DROP_W   = 16;
  localparam int FILL_W   = $clog2(DEPTH) + 1;
  localparam int DROP_MAX = (1 << DROP_W) - 1;

  logic              clk = 1'b0;
  logic              resetN;
  logic              dctValid;
  logic [DATA_W-1:0] dctBuffer;
  logic [CNT_W-1:0]  dctCount;
  logic              testEnding;
  logic              rdReady;

  logic [FILL_W-1:0] fillLvl    [2];
  logic              rdValidLvl [2];
  logic [DATA_W-1:0] rdDataLvl  [2];
  logic [CNT_W-1:0]  rdCountLvl [2];
  logic              ovfLvl     [2];
  logic [DROP_W-1:0] dropLvl    [2];
  logic              endedLvl   [2];

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int lane,
                             input logic [63:0] actual, input logic [63:0] expected);
    compared = compared + 1;
    if (actual !== expected) begin
      mismatched = mismatched + 1;
      $display("[TB] FAIL %s lane%0d at %0t: got %0h, expected %0h", name, lane, $time, actual, expected);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : gLane
    nios2_oci_trace_capture_if #(.DATA_W(DATA_W), .CNT_W(CNT_W), .DEPTH(DEPTH), .DROP_W(DROP_W)) bus ();

    logic [CNT_W+DATA_W-1:0] expQ [$];
    logic [CNT_W+DATA_W-1:0] headWord;
    int mState = 0;
    int mDrop  = 0;
    bit mOvf   = 1'b0;
    bit mEnded = 1'b0;
    bit mWr;
    int mFillBefore;
    int popSeq  = 0;
    int popSeen = 0;

    assign bus.dct_valid   = dctValid;
    assign bus.dct_buffer  = dctBuffer;
    assign bus.dct_count   = dctCount;
    assign bus.test_ending = testEnding;
    assign bus.rd_ready    = rdReady;

    assign fillLvl[g]    = bus.fill_level;
    assign rdValidLvl[g] = bus.rd_valid;
    assign rdDataLvl[g]  = bus.rd_data;
    assign rdCountLvl[g] = bus.rd_count;
    assign ovfLvl[g]     = bus.overflow;
    assign dropLvl[g]    = bus.drop_count;
    assign endedLvl[g]   = bus.test_has_ended;

    nios2_oci_trace_capture #(
      .DATA_W(DATA_W), .CNT_W(CNT_W), .DEPTH(DEPTH),
      .STOP_ON_FULL((g == 0) ? 1 : 0), .DROP_W(DROP_W)
    ) dut (
      .clk    (clk),
      .reset_n(resetN),
      .bus    (bus.slave)
    );

    // Reference model: the queue holds what the buffer should contain; the
    // monitor removes accepted heads, so a full queue here means no pop this edge.
    always @(posedge clk or negedge resetN) begin
      if (!resetN) begin
        expQ.delete();
        mState  = 0;
        mDrop   = 0;
        mOvf    = 1'b0;
        mEnded  = 1'b0;
        popSeen = popSeq;
      end else begin
        mFillBefore = expQ.size() + ((popSeq != popSeen) ? 1 : 0);
        popSeen = popSeq;
        mWr = dctValid && (dctCount != 0) && (mState == 0);
        if (mWr) begin
          if (expQ.size() < DEPTH) begin
            expQ.push_back({dctCount, dctBuffer});
          end else begin
            mOvf = 1'b1;
            if (mDrop < DROP_MAX) mDrop = mDrop + 1;
            if (g == 1) begin
              void'(expQ.pop_front());
              expQ.push_back({dctCount, dctBuffer});
            end
          end
        end
        if (mState == 0 && testEnding) mState = 1;
        else if (mState == 1 && mFillBefore == 0) mState = 2;
        if (mState == 2) mEnded = 1'b1;
      end
    end

    always @(negedge clk) begin
      checkOutput("fill_level", g, 64'(fillLvl[g]), 64'(expQ.size()));
      checkOutput("rd_valid", g, 64'(rdValidLvl[g]), 64'(expQ.size() != 0));
      checkOutput("overflow", g, 64'(ovfLvl[g]), 64'(mOvf));
      checkOutput("drop_count", g, 64'(dropLvl[g]), 64'(mDrop));
      checkOutput("test_has_ended", g, 64'(endedLvl[g]), 64'(mEnded));
      if (!resetN) begin
        checkOutput("rd_data_in_reset", g, 64'(rdDataLvl[g]), 64'd0);
        checkOutput("rd_count_in_reset", g, 64'(rdCountLvl[g]), 64'd0);
      end
      if (expQ.size() != 0) begin
        headWord = expQ[0];
        checkOutput("rd_data", g, 64'(rdDataLvl[g]), 64'(headWord[DATA_W-1:0]));
        checkOutput("rd_count", g, 64'(rdCountLvl[g]), 64'(headWord[DATA_W +: CNT_W]));
        if (rdReady) begin
          void'(expQ.pop_front());
          popSeq = popSeq + 1;
        end
      end
    end
  end

  task automatic applyStimulus(input logic dv, input logic [DATA_W-1:0] data,
                               input logic [CNT_W-1:0] cnt, input logic te, input logic rdy);
    dctValid   = dv;
    dctBuffer  = data;
    dctCount   = cnt;
    testEnding = te;
    rdReady    = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    resetN     = 1'b0;
    dctValid   = 1'b0;
    dctBuffer  = '0;
    dctCount   = '0;
    testEnding = 1'b0;
    rdReady    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    resetN = 1'b1;
  endtask

  task automatic waitEnded(input string name);
    int cycles;
    cycles = 0;
    while (!(endedLvl[0] && endedLvl[1]) && cycles < 60) begin
      applyStimulus(1'b1, DATA_W'($urandom()), 4'd5, 1'b0, 1'b1);
      cycles++;
    end
    checkOutput(name, 0, 64'(endedLvl[0]), 64'd1);
    checkOutput(name, 1, 64'(endedLvl[1]), 64'd1);
  endtask

  initial begin
    doReset();

    // Three writes with no consumer; head visible one cycle after the first write.
    for (int l = 0; l < 2; l++) checkOutput("rd_valid_before_write", l, 64'(rdValidLvl[l]), 64'd0);
    applyStimulus(1'b1, 30'd1, 4'd4, 1'b0, 1'b0);
    for (int l = 0; l < 2; l++) checkOutput("rd_valid_latency", l, 64'(rdValidLvl[l]), 64'd1);
    applyStimulus(1'b1, 30'd2, 4'd4, 1'b0, 1'b0);
    applyStimulus(1'b1, 30'd3, 4'd4, 1'b0, 1'b0);
    for (int l = 0; l < 2; l++) begin
      checkOutput("fill_after_3", l, 64'(fillLvl[l]), 64'd3);
      checkOutput("head_after_3", l, 64'(rdDataLvl[l]), 64'd1);
    end

    // 18 writes into a 16-deep buffer: lane 0 keeps 1..16, lane 1 keeps 3..18.
    doReset();
    for (int i = 1; i <= 18; i++) applyStimulus(1'b1, DATA_W'(i), CNT_W'($urandom_range(1, 15)), 1'b0, 1'b0);
    for (int l = 0; l < 2; l++) begin
      checkOutput("fill_full", l, 64'(fillLvl[l]), 64'd16);
      checkOutput("overflow_full", l, 64'(ovfLvl[l]), 64'd1);
      checkOutput("drop_count_full", l, 64'(dropLvl[l]), 64'd2);
    end
    checkOutput("head_stop_on_full", 0, 64'(rdDataLvl[0]), 64'd1);
    checkOutput("head_overwrite", 1, 64'(rdDataLvl[1]), 64'd3);
    for (int i = 0; i < 16; i++) applyStimulus(1'b0, '0, '0, 1'b0, 1'b1);
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
    for (int l = 0; l < 2; l++) checkOutput("fill_drained", l, 64'(fillLvl[l]), 64'd0);

    // Full buffer with simultaneous write and pop: no drop, new word read last.
    doReset();
    for (int i = 1; i <= 16; i++) applyStimulus(1'b1, DATA_W'(100 + i), 4'd2, 1'b0, 1'b0);
    applyStimulus(1'b1, 30'd200, 4'd3, 1'b0, 1'b1);
    for (int l = 0; l < 2; l++) begin
      checkOutput("fill_wr_pop_full", l, 64'(fillLvl[l]), 64'd16);
      checkOutput("overflow_wr_pop_full", l, 64'(ovfLvl[l]), 64'd0);
    end
    for (int i = 0; i < 15; i++) applyStimulus(1'b0, '0, '0, 1'b0, 1'b1);
    for (int l = 0; l < 2; l++) checkOutput("last_entry", l, 64'(rdDataLvl[l]), 64'd200);
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b1);

    // Random traffic: slow consumer first to force drops, then a faster one.
    doReset();
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(0, 9) < 7), DATA_W'($urandom()), CNT_W'($urandom_range(0, 15)),
                    1'b0, (i < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0));
    end

    // Five words, one-cycle test_ending, consumer always ready.
    doReset();
    for (int i = 1; i <= 5; i++) applyStimulus(1'b1, DATA_W'(i), 4'd6, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b1);
    waitEnded("ended_after_drain");
    for (int l = 0; l < 2; l++) checkOutput("fill_when_done", l, 64'(fillLvl[l]), 64'd0);
    applyStimulus(1'b1, 30'h123, 4'd7, 1'b1, 1'b1);
    for (int l = 0; l < 2; l++) checkOutput("done_ignores_writes", l, 64'(fillLvl[l]), 64'd0);

    // Reset in the middle of a drain with seven words still held.
    doReset();
    for (int i = 1; i <= 10; i++) applyStimulus(1'b1, DATA_W'(50 + i), 4'd1, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, '0, '0, 1'b0, 1'b1);
    for (int l = 0; l < 2; l++) checkOutput("fill_mid_drain", l, 64'(fillLvl[l]), 64'd7);
    resetN = 1'b0;
    #1;
    for (int l = 0; l < 2; l++) begin
      checkOutput("reset_fill", l, 64'(fillLvl[l]), 64'd0);
      checkOutput("reset_rd_valid", l, 64'(rdValidLvl[l]), 64'd0);
      checkOutput("reset_rd_data", l, 64'(rdDataLvl[l]), 64'd0);
      checkOutput("reset_ended", l, 64'(endedLvl[l]), 64'd0);
    end
    repeat (2) @(posedge clk);
    #1;
    resetN = 1'b1;
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, DATA_W'(300 + i), (i % 2 == 1) ? 4'd7 : 4'd0, 1'b0, 1'b0);
    for (int l = 0; l < 2; l++) checkOutput("zero_count_not_stored", l, 64'(fillLvl[l]), 64'd3);
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b1);
    waitEnded("ended_after_reset_drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
